// File: rtl/bus_arbiter.sv
// Two-master, one-slave bus arbiter. M0 is a read-only fetch port and M1 is a load/store port.
// Round-robin between the masters, with a per-transfer wait timeout.
module bus_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_req,
    input  logic [ADDR_W-1:0]   m0_addr,
    output logic                m0_gnt,
    output logic                m0_valid,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_err,
    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wmask,
    output logic                m1_gnt,
    output logic                m1_valid,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_err,
    output logic                s_req,
    output logic                s_we,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wmask,
    input  logic                s_ack,
    input  logic [DATA_W-1:0]   s_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY_M0, BUSY_M1} state_t;

    state_t     state;
    state_t     state_next;
    logic       rr_m1;
    logic [7:0] wait_cnt;
    logic       m0_elig;
    logic       m1_elig;
    logic       grant_m0;
    logic       grant_m1;
    logic       done_ack;
    logic       done_timeout;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // A master whose response strobe is high this cycle is masked so it cannot re-grab the bus.
    always_comb begin
        state_next   = state;
        grant_m0     = 1'b0;
        grant_m1     = 1'b0;
        done_ack     = 1'b0;
        done_timeout = 1'b0;
        m0_elig      = m0_req && !m0_valid;
        m1_elig      = m1_req && !m1_valid;
        case (state)
            IDLE: begin
                if (m0_elig && (!m1_elig || !rr_m1)) begin
                    grant_m0   = 1'b1;
                    state_next = BUSY_M0;
                end else if (m1_elig) begin
                    grant_m1   = 1'b1;
                    state_next = BUSY_M1;
                end
            end
            BUSY_M0, BUSY_M1: begin
                if (s_ack) begin
                    done_ack   = 1'b1;
                    state_next = IDLE;
                end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                    done_timeout = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign s_req  = (state != IDLE);
    assign m0_gnt = (state == BUSY_M0);
    assign m1_gnt = (state == BUSY_M1);

    // Payload is captured only at grant time, so master-side changes during BUSY are invisible to the slave.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_m1    <= 1'b0;
            wait_cnt <= '0;
            s_we     <= 1'b0;
            s_addr   <= '0;
            s_wdata  <= '0;
            s_wmask  <= '0;
            m0_valid <= 1'b0;
            m0_err   <= 1'b0;
            m0_rdata <= '0;
            m1_valid <= 1'b0;
            m1_err   <= 1'b0;
            m1_rdata <= '0;
        end else begin
            m0_valid <= 1'b0;
            m0_err   <= 1'b0;
            m1_valid <= 1'b0;
            m1_err   <= 1'b0;
            if (grant_m0) begin
                rr_m1    <= 1'b1;
                wait_cnt <= '0;
                s_we     <= 1'b0;
                s_addr   <= m0_addr;
                s_wdata  <= '0;
                s_wmask  <= '0;
            end else if (grant_m1) begin
                rr_m1    <= 1'b0;
                wait_cnt <= '0;
                s_we     <= m1_we;
                s_addr   <= m1_addr;
                s_wdata  <= m1_wdata;
                s_wmask  <= m1_wmask;
            end else if (s_req && !s_ack) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (done_ack || done_timeout) begin
                if (state == BUSY_M0) begin
                    m0_valid <= 1'b1;
                    m0_err   <= done_timeout;
                    m0_rdata <= done_ack ? s_rdata : '0;
                end else begin
                    m1_valid <= 1'b1;
                    m1_err   <= done_timeout;
                    m1_rdata <= done_ack ? s_rdata : '0;
                end
            end
        end
    end

endmodule
